// File: rtl/apb_mem_pkg.sv
// Shared types and default parameter values for the APB parameterised memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DEPTH       = 256;
  localparam int unsigned DEF_WAIT_CYCLES = 0;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/apb_mem_array.sv
// Byte-enabled storage: one synchronous write port, one asynchronous read port.
module apb_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_strb,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  assign w_old = r_mem[i_waddr];

  // Lanes with strobe low keep their stored byte.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign w_merged[g*8 +: 8] = i_strb[g] ? i_wdata[g*8 +: 8] : w_old[g*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= w_merged;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_param_mem_slave.sv
// APB slave fronting a byte-enabled memory with fixed wait states, external stall
// and out-of-range error response.
module apb_param_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel,
  input  logic                enable,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] strb,
  input  logic                ext_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                slverr
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  apb_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [DATA_W-1:0]  r_wdata;
  logic [NB-1:0]      r_strb;
  logic               r_oor;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_ready;
  logic               w_done;
  logic               w_we;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_mem_rdata;

  assign w_ready = (r_state == ACCESS) && (r_cnt == '0) && ext_ready;
  assign w_done  = w_ready && sel && enable;
  // Reset on the completing edge must suppress the commit.
  assign w_we    = w_done && r_write && !r_oor && rst_n;
  assign w_idx   = IDX_W'(r_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sel && !enable) begin
            r_state <= SETUP;
            r_addr  <= addr;
            r_write <= write;
            r_wdata <= wdata;
            r_strb  <= strb;
            r_oor   <= ({1'b0, addr} >= DEPTH_L);
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= CNT_W'(WAIT_CYCLES);
          r_rdata <= r_oor ? '0 : w_mem_rdata;
        end
        ACCESS: begin
          // Completion and abort both return to IDLE; a new setup is taken from there.
          if (!(sel && enable) || w_ready) r_state <= IDLE;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_wdata),
    .i_strb  (r_strb),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  assign rdata  = r_rdata;
  assign ready  = w_ready;
  assign slverr = w_ready && r_oor;

endmodule

// File: tb/tb_apb_param_mem_slave.sv
// Bench for apb_param_mem_slave: three configurations behind one shared APB master,
// checked against a word-level memory model.
module tb_apb_param_mem_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel_v;
  logic        enable;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        ext_ready;
  logic [7:0]  rdata0;
  logic [31:0] rdata1;
  logic [7:0]  rdata2;
  logic [2:0]  ready_v;
  logic [2:0]  slverr_v;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl   [3][256];
  bit          known [3][256];

  logic [31:0] rd;
  logic [1:0]  r_d;
  bit          r_wr;
  logic [7:0]  r_a;
  logic [31:0] r_wd;
  logic [3:0]  r_st;
  int          r_low;

  // d0: defaults; d1: 32-bit, 64 words; d2: 8-bit, 3 wait states
  apb_param_mem_slave u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[0]), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata[7:0]), .strb(strb[0:0]), .ext_ready(ext_ready),
    .rdata(rdata0), .ready(ready_v[0]), .slverr(slverr_v[0]));

  apb_param_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[1]), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .strb(strb), .ext_ready(ext_ready),
    .rdata(rdata1), .ready(ready_v[1]), .slverr(slverr_v[1]));

  apb_param_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[2]), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata[7:0]), .strb(strb[0:0]), .ext_ready(ext_ready),
    .rdata(rdata2), .ready(ready_v[2]), .slverr(slverr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int dut_depth(input logic [1:0] d);
    return (d == 2'd1) ? 64 : 256;
  endfunction

  function automatic int dut_wait(input logic [1:0] d);
    return (d == 2'd2) ? 3 : 0;
  endfunction

  function automatic int dut_nb(input logic [1:0] d);
    return (d == 2'd1) ? 4 : 1;
  endfunction

  function automatic logic [31:0] rd_of(input logic [1:0] d);
    case (d)
      2'd0:    return {24'd0, rdata0};
      2'd1:    return rdata1;
      default: return {24'd0, rdata2};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st, input int nb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < nb; i++) if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer; lat counts ACCESS cycles up to and including the ready cycle.
  task automatic xfer(input logic [1:0] d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input int n_low,
                      output logic [31:0] o_rd, output logic o_err, output int lat);
    bit done;
    sel_v = 3'b001 << d; enable = 1'b0; write = wr; addr = a; wdata = wd; strb = st;
    ext_ready = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    #1 check_eq("setup_ready", 32'(ready_v[d]), 32'd0);
    @(posedge clk); #1;
    lat = 0; o_rd = '0; o_err = 1'b0; done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      ext_ready = (k <= n_low) ? 1'b0 : 1'b1;
      #1;
      if (ready_v[d]) begin
        lat = k; o_rd = rd_of(d); o_err = slverr_v[d]; done = 1'b1;
      end else begin
        check_eq("slverr_without_ready", 32'(slverr_v[d]), 32'd0);
      end
      @(posedge clk); #1;
    end
    sel_v = '0; enable = 1'b0; ext_ready = 1'b1;
  endtask

  task automatic run(input logic [1:0] d, input bit wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input int n_low,
                     output logic [31:0] o_rd);
    logic err;
    int   lat;
    int   exp_lat;
    bit   oor;
    bit   full;
    oor     = int'(a) >= dut_depth(d);
    exp_lat = ((dut_wait(d) > n_low) ? dut_wait(d) : n_low) + 1;
    xfer(d, wr, a, wd, st, n_low, o_rd, err, lat);
    check_eq($sformatf("d%0d latency a=%0d", d, a), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("d%0d slverr a=%0d", d, a), 32'(err), 32'(oor));
    if (wr) begin
      if (!oor) begin
        full = 1'b1;
        for (int i = 0; i < dut_nb(d); i++) if (!st[i]) full = 1'b0;
        mdl[d][a]   = merge(mdl[d][a], wd, st, dut_nb(d));
        known[d][a] = known[d][a] | full;
      end
    end else if (oor) begin
      check_eq($sformatf("d%0d oor rdata a=%0d", d, a), o_rd, 32'd0);
    end else if (known[d][a]) begin
      check_eq($sformatf("d%0d rdata a=%0d", d, a), o_rd, mdl[d][a]);
    end
  endtask

  // Start a full-strobe write on d, then kill it in the third ACCESS cycle.
  task automatic abort_write(input logic [1:0] d, input logic [7:0] a,
                             input logic [31:0] wd, input bit by_reset);
    sel_v = 3'b001 << d; enable = 1'b0; write = 1'b1; addr = a; wdata = wd; strb = 4'hF;
    ext_ready = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    if (by_reset) rst_n = 1'b0;
    else          sel_v = '0;
    #1 check_eq("abort_ready", 32'(ready_v[d]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check_eq("post_abort_ready", 32'(ready_v[d]), 32'd0);
    check_eq("post_abort_slverr", 32'(slverr_v[d]), 32'd0);
    @(posedge clk); #1;
    sel_v = '0; enable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++) begin mdl[d][a] = '0; known[d][a] = 1'b0; end
    rst_n = 1'b0; sel_v = '0; enable = 1'b0; write = 1'b0; addr = '0;
    wdata = '0; strb = '0; ext_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("reset ready d%0d", d), 32'(ready_v[d]), 32'd0);
      check_eq($sformatf("reset slverr d%0d", d), 32'(slverr_v[d]), 32'd0);
      check_eq($sformatf("reset rdata d%0d", d), rd_of(2'(d)), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2'd0, 1'b1, 8'd6, 32'd5, 4'h1, 0, rd);
    run(2'd0, 1'b0, 8'd6, 32'd0, 4'h0, 0, rd);
    check_eq("zero_wait_read", rd, 32'd5);

    run(2'd0, 1'b1, 8'd5, 32'd4, 4'h1, 5, rd);
    run(2'd0, 1'b0, 8'd5, 32'd0, 4'h0, 0, rd);
    check_eq("stalled_write_read", rd, 32'd4);

    run(2'd2, 1'b1, 8'd3, 32'd2, 4'h1, 0, rd);
    run(2'd2, 1'b0, 8'd3, 32'd0, 4'h0, 0, rd);
    check_eq("wait3_read", rd, 32'd2);

    run(2'd1, 1'b1, 8'd2, 32'hAABBCCDD, 4'b1111, 0, rd);
    run(2'd1, 1'b1, 8'd2, 32'h11223344, 4'b0101, 0, rd);
    run(2'd1, 1'b0, 8'd2, 32'd0, 4'h0, 0, rd);
    check_eq("byte_strobe_merge", rd, 32'hAA22CC44);

    // Address 70 aliases word 6 in a 64-word array; it must not be touched.
    run(2'd1, 1'b1, 8'd6, 32'hCAFEF00D, 4'hF, 0, rd);
    run(2'd1, 1'b1, 8'd70, 32'hDEADBEEF, 4'hF, 0, rd);
    run(2'd1, 1'b0, 8'd6, 32'd0, 4'h0, 0, rd);
    check_eq("oor_write_no_alias", rd, 32'hCAFEF00D);
    run(2'd1, 1'b0, 8'd70, 32'd0, 4'h0, 0, rd);

    sel_v = 3'b100; enable = 1'b1; write = 1'b0; addr = 8'd3;
    repeat (3) begin
      @(posedge clk); #1;
      #1 check_eq("idle_enable_ignored", 32'(ready_v[2]), 32'd0);
    end
    sel_v = '0; enable = 1'b0;
    @(posedge clk); #1;
    run(2'd2, 1'b0, 8'd3, 32'd0, 4'h0, 0, rd);
    check_eq("after_idle_enable", rd, 32'd2);

    abort_write(2'd2, 8'd3, 32'h77, 1'b0);
    run(2'd2, 1'b0, 8'd3, 32'd0, 4'h0, 0, rd);
    check_eq("sel_abort_no_write", rd, 32'd2);

    abort_write(2'd2, 8'd3, 32'h99, 1'b1);
    run(2'd2, 1'b0, 8'd3, 32'd0, 4'h0, 0, rd);
    check_eq("reset_abort_no_write", rd, 32'd2);
    run(2'd1, 1'b0, 8'd2, 32'd0, 4'h0, 0, rd);
    check_eq("memory_survives_reset", rd, 32'hAA22CC44);

    for (int it = 0; it < 250; it++) begin
      r_d  = 2'($urandom_range(0, 2));
      r_wr = ($urandom_range(0, 1) == 1);
      r_a  = (r_d == 2'd1) ? 8'($urandom_range(0, 79)) : 8'($urandom_range(0, 15));
      r_wd = $urandom;
      r_st = 4'($urandom_range(0, 15));
      r_low = (dut_wait(r_d) == 0) ? int'($urandom_range(0, 3)) : 0;
      run(r_d, r_wr, r_a, r_wd, r_st, r_low, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
